// File: rtl/bus_timer_pkg.sv
// Shared register map, control/status bit positions and count type for bus_timer.
package bus_timer_pkg;

    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_STAT  = 4'd1;
    localparam logic [3:0] REG_RLD_L = 4'd2;
    localparam logic [3:0] REG_RLD_H = 4'd3;
    localparam logic [3:0] REG_CNT_L = 4'd4;
    localparam logic [3:0] REG_CNT_H = 4'd5;
    localparam logic [3:0] REG_PRE   = 4'd6;
    localparam logic [3:0] REG_CAP_L = 4'd8;
    localparam logic [3:0] REG_CAP_H = 4'd9;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_CIE  = 3;

    localparam int STAT_IF = 0;
    localparam int STAT_CF = 1;

    typedef logic [15:0] count_t;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Clock divider for bus_timer: pcnt runs 0..pre while enabled, tick fires combinationally on pre.
// A clear forces pcnt to 0 and suppresses that cycle's tick so a reload or stop wins cleanly.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] pre,
    output logic       tick
);

    logic [7:0] pcnt;
    logic       at_top;

    assign at_top = (pcnt == pre);
    assign tick   = en & at_top & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= 8'h00;
        end else if (clr || !en || at_top) begin
            pcnt <= 8'h00;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// 16-bit interval timer on the 6502 peripheral bus: writes at the edge, read data registered one cycle later.
// Optional capture input (cap_i, CAP regs, CF/CIE) is built only when TIMER_CAPTURE_EN is defined.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [15:0] RST_RELOAD   = 16'hFFFF,
    parameter logic [7:0]  RST_PRESCALE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic       cap_i
`endif
);

    logic [3:0] ctrl;
    logic [3:0] ctrl_nxt;
    logic       flag_if;
    logic       flag_cf;
    count_t     rld;
    count_t     cnt;
    count_t     cap;
    logic [7:0] pre;
    logic [7:0] cnt_h_lat;
    logic [7:0] rdata;

    logic wr;
    logic rd;
    logic wr_ctrl;
    logic wr_stat;
    logic wr_rld_l;
    logic wr_rld_h;
    logic wr_pre;
    logic ctrl_en;
    logic ctrl_auto;
    logic ctrl_ie;
    logic ctrl_cie;
    logic pre_clr;
    logic tick;
    logic underflow;

    assign wr       = cs & we;
    assign rd       = cs & ~we;
    assign wr_ctrl  = wr && (rs == REG_CTRL);
    assign wr_stat  = wr && (rs == REG_STAT);
    assign wr_rld_l = wr && (rs == REG_RLD_L);
    assign wr_rld_h = wr && (rs == REG_RLD_H);
    assign wr_pre   = wr && (rs == REG_PRE);

    assign ctrl_en   = ctrl[CTRL_EN];
    assign ctrl_auto = ctrl[CTRL_AUTO];
    assign ctrl_ie   = ctrl[CTRL_IE];
    assign ctrl_cie  = ctrl[CTRL_CIE];

    // Restart the divide phase on a reload, on enable, and on any stop so no stale tick leaks out.
    assign pre_clr   = wr_rld_h | (wr_ctrl & (~din[CTRL_EN] | ~ctrl_en));
    assign underflow = tick & (cnt == 16'h0000);

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_en),
        .clr   (pre_clr),
        .pre   (pre),
        .tick  (tick)
    );

`ifdef TIMER_CAPTURE_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;

    logic [2:0] cap_sync;
    logic       cap_edge;

    // Two flops of synchronisation, third flop only for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_sync <= 3'b000;
        end else begin
            cap_sync <= {cap_sync[1:0], cap_i};
        end
    end

    assign cap_edge = cap_sync[1] & ~cap_sync[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap <= 16'h0000;
        end else if (cap_edge) begin
            cap <= cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_cf <= 1'b0;
        end else if (cap_edge) begin
            flag_cf <= 1'b1;
        end else if (wr_stat && din[STAT_CF]) begin
            flag_cf <= 1'b0;
        end
    end
`else
    localparam logic [3:0] CTRL_WMASK = 4'h7;

    assign cap     = 16'h0000;
    assign flag_cf = 1'b0;
`endif

    // One-shot underflow clears EN after any same-cycle CPU write has been applied.
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr_ctrl) begin
            ctrl_nxt = din[3:0] & CTRL_WMASK;
        end
        if (underflow && !ctrl_auto) begin
            ctrl_nxt[CTRL_EN] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'h0;
            rld  <= RST_RELOAD;
            pre  <= RST_PRESCALE;
        end else begin
            ctrl <= ctrl_nxt;
            if (wr_rld_l) begin
                rld[7:0] <= din;
            end
            if (wr_rld_h) begin
                rld[15:8] <= din;
            end
            if (wr_pre) begin
                pre <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= RST_RELOAD;
        end else if (wr_rld_h) begin
            cnt <= {din, rld[7:0]};
        end else if (tick) begin
            if (cnt != 16'h0000) begin
                cnt <= cnt - 16'd1;
            end else if (ctrl_auto) begin
                cnt <= rld;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_if <= 1'b0;
        end else if (underflow) begin
            flag_if <= 1'b1;
        end else if (wr_stat && din[STAT_IF]) begin
            flag_if <= 1'b0;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (rs)
            REG_CTRL:  rdata = {4'h0, ctrl};
            REG_STAT:  rdata = {6'h00, flag_cf, flag_if};
            REG_RLD_L: rdata = rld[7:0];
            REG_RLD_H: rdata = rld[15:8];
            REG_CNT_L: rdata = cnt[7:0];
            REG_CNT_H: rdata = cnt_h_lat;
            REG_PRE:   rdata = pre;
            REG_CAP_L: rdata = cap[7:0];
            REG_CAP_H: rdata = cap[15:8];
            default:   rdata = 8'h00;
        endcase
    end

    // Reading CNT_L freezes the high byte so a following CNT_H read is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout      <= 8'h00;
            cnt_h_lat <= 8'h00;
        end else if (rd) begin
            dout <= rdata;
            if (rs == REG_CNT_L) begin
                cnt_h_lat <= cnt[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (flag_if & ctrl_ie) | (flag_cf & ctrl_cie);
        end
    end

endmodule
